// File: rtl/jk_mod_counter_pkg.sv
// Shared types for the JK modulo counter: the {J,K} command encoding and a
// reference next-state helper for modelling a single JK cell.
package jk_mod_counter_pkg;

  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_RESET  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_cmd_e;

  function automatic logic jk_next(input logic q, input jk_cmd_e cmd);
    logic nextQ;
    case (cmd)
      JK_HOLD:   nextQ = q;
      JK_RESET:  nextQ = 1'b0;
      JK_SET:    nextQ = 1'b1;
      JK_TOGGLE: nextQ = ~q;
      default:   nextQ = q;
    endcase
    return nextQ;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with synchronous active-high reset; one per counter bit.
module jk_cell (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  logic state_q;
  logic state_d;

  always_comb begin
    state_d = (j & ~state_q) | (~k & state_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= 1'b0;
    end else begin
      state_q <= state_d;
    end
  end

  assign q = state_q;

endmodule

// File: rtl/jk_mod_counter.sv
// Up/down modulo-MODULUS counter: per-bit J/K decode feeding a chain of JK cells,
// plus a combinational terminal-count flag and a registered illegal-load flag.
module jk_mod_counter
  import jk_mod_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             load_err
);

  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
    $error("jk_mod_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end

  localparam logic [WIDTH-1:0] LastVal = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   ModWide = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] jVec;
  logic [WIDTH-1:0] kVec;
  logic [WIDTH-1:0] upToggle;
  logic [WIDTH-1:0] dnToggle;
  logic             isLast;
  logic             isZero;
  logic             loadIllegal;
  logic             load_err_q;
  logic             load_err_d;

  assign isLast      = (q == LastVal);
  assign isZero      = (q == '0);
  assign loadIllegal = ({1'b0, din} >= ModWide);

  // Bit i toggles when all lower bits are 1 (counting up) or all 0 (counting down).
  always_comb begin
    upToggle    = '0;
    dnToggle    = '0;
    upToggle[0] = 1'b1;
    dnToggle[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      upToggle[i] = upToggle[i-1] & q[i-1];
      dnToggle[i] = dnToggle[i-1] & ~q[i-1];
    end
  end

  always_comb begin
    jVec       = '0;
    kVec       = '0;
    load_err_d = 1'b0;
    if (load) begin
      if (loadIllegal) begin
        kVec       = '1;
        load_err_d = 1'b1;
      end else begin
        jVec = din;
        kVec = ~din;
      end
    end else if (en) begin
      if (up) begin
        if (isLast) begin
          kVec = '1;
        end else begin
          jVec = upToggle;
          kVec = upToggle;
        end
      end else begin
        if (isZero) begin
          jVec = LastVal;
          kVec = ~LastVal;
        end else begin
          jVec = dnToggle;
          kVec = dnToggle;
        end
      end
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell u_cell (
      .clk (clk),
      .rst (rst),
      .j   (jVec[i]),
      .k   (kVec[i]),
      .q   (q[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      load_err_q <= 1'b0;
    end else begin
      load_err_q <= load_err_d;
    end
  end

  assign load_err = load_err_q;
  assign tc       = en & ((up & isLast) | (~up & isZero));

endmodule

// File: tb/tb_jk_mod_counter.sv
// Self-checking bench for jk_mod_counter: arithmetic reference model checked every
// cycle, plus directed vectors with literal expected values.
module tb_jk_mod_counter;
  import jk_mod_counter_pkg::*;

  localparam int W = 4;
  localparam int M = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         up = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] din = '0;
  logic [W-1:0] q;
  logic         tc;
  logic         load_err;

  int checkCount = 0;
  int passCount  = 0;

  int mQ     = 0;
  bit mErr   = 1'b0;
  bit mValid = 1'b0;

  jk_mod_counter #(.WIDTH(W), .MODULUS(M)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .load     (load),
    .din      (din),
    .q        (q),
    .tc       (tc),
    .load_err (load_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end else begin
      passCount++;
    end
  endtask

  // Reference model: plain modulo arithmetic on the count.
  always @(posedge clk) begin
    if (rst) begin
      mQ     = 0;
      mErr   = 1'b0;
      mValid = 1'b1;
    end else if (load) begin
      if (int'(din) < M) begin
        mQ   = int'(din);
        mErr = 1'b0;
      end else begin
        mQ   = 0;
        mErr = 1'b1;
      end
    end else begin
      mErr = 1'b0;
      if (en) mQ = up ? (mQ + 1) % M : (mQ + M - 1) % M;
    end
  end

  // Compare process: inputs for the coming edge are already applied here.
  always @(negedge clk) begin
    #3;
    if (mValid) begin
      checkOutput("model_q", 32'(q), 32'(mQ));
      checkOutput("model_load_err", 32'(load_err), 32'(mErr));
      checkOutput("model_tc", 32'(tc),
                  32'(en && ((up && mQ == M - 1) || (!up && mQ == 0))));
    end
  end

  // Drive one cycle of inputs; expTc < 0 skips the pre-edge tc check.
  task automatic applyStimulus(input logic r, input logic e, input logic u, input logic l,
                               input logic [W-1:0] d, input int expTc,
                               input int expQ, input int expErr);
    @(negedge clk);
    #1;
    rst  = r;
    en   = e;
    up   = u;
    load = l;
    din  = d;
    #1;
    if (expTc >= 0) checkOutput("tc_before_edge", 32'(tc), 32'(expTc));
    @(posedge clk);
    #1;
    checkOutput("q_after_edge", 32'(q), 32'(expQ));
    checkOutput("load_err_after_edge", 32'(load_err), 32'(expErr));
  endtask

  int downTc[5]  = '{0, 0, 0, 1, 0};
  int downQ[5]   = '{2, 1, 0, 9, 8};

  initial begin
    checkOutput("jk_next_hold", 32'(jk_next(1'b1, JK_HOLD)), 32'd1);
    checkOutput("jk_next_reset", 32'(jk_next(1'b1, JK_RESET)), 32'd0);
    checkOutput("jk_next_set", 32'(jk_next(1'b0, JK_SET)), 32'd1);
    checkOutput("jk_next_toggle", 32'(jk_next(1'b1, JK_TOGGLE)), 32'd0);

    // Reset overrides load and enable.
    applyStimulus(1, 1, 1, 1, 4'd7, -1, 0, 0);
    applyStimulus(1, 1, 1, 1, 4'd7, 0, 0, 0);

    // Count up through the wrap.
    for (int i = 0; i < 12; i++)
      applyStimulus(0, 1, 1, 0, 4'd0, ((i % 10) == 9) ? 1 : 0, (i + 1) % 10, 0);

    // Hold.
    applyStimulus(0, 0, 1, 0, 4'd0, 0, 2, 0);

    // Load 3 then count down through the wrap.
    applyStimulus(0, 1, 0, 1, 4'd3, 0, 3, 0);
    for (int i = 0; i < 5; i++)
      applyStimulus(0, 1, 0, 0, 4'd0, downTc[i], downQ[i], 0);

    // Illegal / legal / illegal loads, then release.
    applyStimulus(0, 0, 1, 1, 4'd12, 0, 0, 1);
    applyStimulus(0, 0, 1, 1, 4'd9, 0, 9, 0);
    applyStimulus(0, 0, 1, 1, 4'd10, 0, 0, 1);
    applyStimulus(0, 0, 1, 0, 4'd0, 0, 0, 0);
    applyStimulus(0, 0, 1, 1, 4'd15, 0, 0, 1);

    // Load beats count at the terminal value.
    applyStimulus(0, 0, 1, 1, 4'd9, 0, 9, 0);
    applyStimulus(0, 1, 1, 1, 4'd5, 1, 5, 0);

    // Reset mid-count.
    applyStimulus(0, 1, 1, 0, 4'd0, 0, 6, 0);
    applyStimulus(1, 1, 1, 0, 4'd0, 0, 0, 0);

    // Direction changes from a load of 0.
    applyStimulus(0, 0, 1, 1, 4'd0, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 4'd0, 0, 1, 0);
    applyStimulus(0, 1, 0, 0, 4'd0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 4'd0, 1, 9, 0);
    applyStimulus(0, 1, 0, 0, 4'd0, 0, 8, 0);
    applyStimulus(0, 1, 1, 0, 4'd0, 0, 9, 0);

    // Reset during a pending wrap.
    applyStimulus(1, 1, 1, 0, 4'd0, 1, 0, 0);
    applyStimulus(0, 1, 1, 0, 4'd0, 0, 1, 0);

    @(negedge clk);
    #5;
    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
